// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU function codes,
// I-type opcodes, flag bit positions and mux-select encodings.
package ex_stage_pkg;

   localparam int unsigned GPR_WIDTH = 32;
   localparam int unsigned PC_WIDTH  = 32;

   // ALU function codes (R-type funct field)
   localparam logic [5:0] FN_LSL  = 6'h00;
   localparam logic [5:0] FN_LSR  = 6'h02;
   localparam logic [5:0] FN_ASR  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_NOT  = 6'h28;
   localparam logic [5:0] FN_XNOR = 6'h29;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_NAND = 6'h2B;

   // Opcodes; immediate forms reuse the register-form ALU function codes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   // Flag register bit positions: {true, overflow, carry, zero, neg}
   localparam int unsigned FL_NEG   = 0;
   localparam int unsigned FL_ZERO  = 1;
   localparam int unsigned FL_CARRY = 2;
   localparam int unsigned FL_OVF   = 3;
   localparam int unsigned FL_TRUE  = 4;

   typedef enum logic [1:0] {FwIdEx = 2'd0, FwMem = 2'd1, FwWb = 2'd2, FwIdExAlt = 2'd3} fw_sel_e;
   typedef enum logic [1:0] {DstRd = 2'd0, DstRt = 2'd1, DstRa = 2'd2, DstZero = 2'd3} reg_dst_e;

   // ALU function used by an immediate-form opcode (used by decode)
   function automatic logic [5:0] imm_op_funct(input logic [5:0] op);
      case (op)
         OP_ADDI: imm_op_funct = FN_ADD;
         OP_ANDI: imm_op_funct = FN_AND;
         OP_ORI:  imm_op_funct = FN_OR;
         OP_SLTI: imm_op_funct = FN_SLT;
         default: imm_op_funct = 6'h3F;
      endcase
   endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: result and computed flags {true, ovf, carry, zero, neg}.
module alu
   import ex_stage_pkg::*;
(
   input  logic [GPR_WIDTH-1:0] i_a,
   input  logic [GPR_WIDTH-1:0] i_b,
   input  logic [5:0]           i_funct,
   output logic [GPR_WIDTH-1:0] o_result,
   output logic [4:0]           o_flags
);

   localparam int unsigned Msb = GPR_WIDTH - 1;

   logic [GPR_WIDTH:0]   w_sum;
   logic [GPR_WIDTH:0]   w_diff;
   logic [4:0]           w_shamt;
   logic                 w_carry;
   logic                 w_ovf;
   logic                 w_known;

   assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
   assign w_shamt = i_b[4:0];

   // Select the operation result; unknown codes produce zero and clear every flag
   always_comb begin
      o_result = '0;
      w_carry  = 1'b0;
      w_ovf    = 1'b0;
      w_known  = 1'b1;
      case (i_funct)
         FN_ADD: begin
            o_result = w_sum[Msb:0];
            w_carry  = w_sum[GPR_WIDTH];
            w_ovf    = (i_a[Msb] == i_b[Msb]) && (w_sum[Msb] != i_a[Msb]);
         end
         FN_SUB: begin
            o_result = w_diff[Msb:0];
            w_carry  = w_diff[GPR_WIDTH];
            w_ovf    = (i_a[Msb] != i_b[Msb]) && (w_diff[Msb] != i_a[Msb]);
         end
         FN_AND:  o_result = i_a & i_b;
         FN_OR:   o_result = i_a | i_b;
         FN_NOT:  o_result = ~i_a;
         FN_XOR:  o_result = i_a ^ i_b;
         FN_NOR:  o_result = ~(i_a | i_b);
         FN_XNOR: o_result = ~(i_a ^ i_b);
         FN_NAND: o_result = ~(i_a & i_b);
         FN_LSL:  o_result = i_a << w_shamt;
         FN_LSR:  o_result = i_a >> w_shamt;
         FN_ASR:  o_result = $signed(i_a) >>> w_shamt;
         FN_SLT:  o_result = {{(GPR_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         default: w_known = 1'b0;
      endcase
   end

   // Assemble flags from the selected result
   always_comb begin
      o_flags = '0;
      if (w_known) begin
         o_flags[FL_TRUE]  = 1'b1;
         o_flags[FL_OVF]   = w_ovf;
         o_flags[FL_CARRY] = w_carry;
         o_flags[FL_ZERO]  = (o_result == '0);
         o_flags[FL_NEG]   = o_result[Msb];
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, flag register
// and the EX/MEM pipeline register.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [5:0]           i_alu_funct,
   input  logic                 i_alu_src_mux,
   input  logic [1:0]           i_reg_dst_mux,
   input  logic                 i_is_load,
   input  logic                 i_fl_write_enable,
   input  logic                 i_mem_write_enable,
   input  logic                 i_sel_beq_bne,
   input  logic                 i_sel_jt_jf,
   input  logic                 i_is_branch,
   input  logic                 i_sel_jflag_branch,
   input  logic [1:0]           i_wb_res_mux,
   input  logic                 i_reg_write_enable,
   input  logic [4:0]           i_rd,
   input  logic [4:0]           i_rs,
   input  logic [4:0]           i_rt,
   input  logic [GPR_WIDTH-1:0] i_imm,
   input  logic [PC_WIDTH-1:0]  i_next_pc,
   input  logic [GPR_WIDTH-1:0] i_data_rs,
   input  logic [GPR_WIDTH-1:0] i_data_rt,
   input  logic [1:0]           i_fw_sel_a,
   input  logic [1:0]           i_fw_sel_b,
   input  logic [GPR_WIDTH-1:0] i_mem_fw_data,
   input  logic [GPR_WIDTH-1:0] i_wb_fw_data,
   output logic                 o_branch_taken,
   output logic [PC_WIDTH-1:0]  o_branch_addr,
   output logic [GPR_WIDTH-1:0] o_alu_res,
   output logic [GPR_WIDTH-1:0] o_data_rt,
   output logic [GPR_WIDTH-1:0] o_imm,
   output logic [PC_WIDTH-1:0]  o_next_pc,
   output logic [4:0]           o_wr_reg,
   output logic                 o_is_load,
   output logic                 o_mem_write_enable,
   output logic                 o_reg_write_enable,
   output logic [1:0]           o_wb_res_mux,
   output logic [4:0]           o_flags
);

   logic [GPR_WIDTH-1:0] w_op_a;
   logic [GPR_WIDTH-1:0] w_fwd_b;
   logic [GPR_WIDTH-1:0] w_op_b;
   logic [GPR_WIDTH-1:0] w_alu_res;
   logic [4:0]           w_alu_flags;
   logic [4:0]           w_wr_reg;
   logic [7:0]           w_flag_vec;
   logic                 w_flag_cond;

   logic [4:0]           r_flags;
   logic [GPR_WIDTH-1:0] r_alu_res;
   logic [GPR_WIDTH-1:0] r_data_rt;
   logic [GPR_WIDTH-1:0] r_imm;
   logic [PC_WIDTH-1:0]  r_next_pc;
   logic [4:0]           r_wr_reg;
   logic                 r_is_load;
   logic                 r_mem_write_enable;
   logic                 r_reg_write_enable;
   logic [1:0]           r_wb_res_mux;

   // Forwarding muxes; B is forwarded before the immediate select
   always_comb begin
      w_op_a  = i_data_rs;
      w_fwd_b = i_data_rt;
      case (fw_sel_e'(i_fw_sel_a))
         FwMem:   w_op_a = i_mem_fw_data;
         FwWb:    w_op_a = i_wb_fw_data;
         default: w_op_a = i_data_rs;
      endcase
      case (fw_sel_e'(i_fw_sel_b))
         FwMem:   w_fwd_b = i_mem_fw_data;
         FwWb:    w_fwd_b = i_wb_fw_data;
         default: w_fwd_b = i_data_rt;
      endcase
      w_op_b = i_alu_src_mux ? i_imm : w_fwd_b;
   end

   alu u_alu (
      .i_a      (w_op_a),
      .i_b      (w_op_b),
      .i_funct  (i_alu_funct),
      .o_result (w_alu_res),
      .o_flags  (w_alu_flags)
   );

   // Branch resolution against the pre-edge flag register; not gated by reset
   always_comb begin
      w_flag_vec     = {3'b000, r_flags};
      w_flag_cond    = (i_rs[4:3] == 2'b00) ? w_flag_vec[i_rs[2:0]] : 1'b0;
      o_branch_taken = 1'b0;
      if (i_is_branch) begin
         if (i_sel_jflag_branch) o_branch_taken = w_flag_cond ^ i_sel_jt_jf;
         else                    o_branch_taken = (w_op_a == w_op_b) ^ i_sel_beq_bne;
      end
      o_branch_addr = i_next_pc + i_imm[PC_WIDTH-1:0];
   end

   // Destination register select
   always_comb begin
      w_wr_reg = '0;
      case (reg_dst_e'(i_reg_dst_mux))
         DstRd:   w_wr_reg = i_rd;
         DstRt:   w_wr_reg = i_rt;
         DstRa:   w_wr_reg = 5'd31;
         default: w_wr_reg = '0;
      endcase
   end

   // Flag register and EX/MEM register; reset wins over capture
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_flags            <= '0;
         r_alu_res          <= '0;
         r_data_rt          <= '0;
         r_imm              <= '0;
         r_next_pc          <= '0;
         r_wr_reg           <= '0;
         r_is_load          <= 1'b0;
         r_mem_write_enable <= 1'b0;
         r_reg_write_enable <= 1'b0;
         r_wb_res_mux       <= '0;
      end else begin
         if (i_fl_write_enable) r_flags <= w_alu_flags;
         r_alu_res          <= w_alu_res;
         r_data_rt          <= w_fwd_b;
         r_imm              <= i_imm;
         r_next_pc          <= i_next_pc;
         r_wr_reg           <= w_wr_reg;
         r_is_load          <= i_is_load;
         r_mem_write_enable <= i_mem_write_enable;
         r_reg_write_enable <= i_reg_write_enable;
         r_wb_res_mux       <= i_wb_res_mux;
      end
   end

   assign o_alu_res          = r_alu_res;
   assign o_data_rt          = r_data_rt;
   assign o_imm              = r_imm;
   assign o_next_pc          = r_next_pc;
   assign o_wr_reg           = r_wr_reg;
   assign o_is_load          = r_is_load;
   assign o_mem_write_enable = r_mem_write_enable;
   assign o_reg_write_enable = r_reg_write_enable;
   assign o_wb_res_mux       = r_wb_res_mux;
   assign o_flags            = r_flags;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases plus random instructions against a
// behavioural model, with queued expectations checked by separate monitors.
module tb_ex_stage;
   import ex_stage_pkg::*;

   typedef struct packed {
      logic        rst;
      logic [5:0]  funct;
      logic        alu_src;
      logic [1:0]  reg_dst;
      logic        is_load, fwe, mwe, beq_bne, jt_jf, is_branch, jflag;
      logic [1:0]  wb_mux;
      logic        rwe;
      logic [4:0]  rd, rs, rt;
      logic [31:0] imm, next_pc, data_rs, data_rt;
      logic [1:0]  fw_a, fw_b;
      logic [31:0] mem_fw, wb_fw;
   } stim_t;

   typedef struct packed {
      logic [31:0] alu_res, data_rt, imm, next_pc;
      logic [4:0]  wr_reg;
      logic [4:0]  ctl;
      logic [4:0]  flags;
   } exp_t;

   typedef struct packed {
      logic        taken;
      logic [31:0] addr;
   } br_t;

   logic clk = 1'b0;
   stim_t s;
   logic        branch_taken;
   logic [31:0] branch_addr, alu_res, data_rt, imm, next_pc;
   logic [4:0]  wr_reg, flags;
   logic        is_load, mwe, rwe;
   logic [1:0]  wb_mux;

   exp_t exp_q[$];
   br_t  br_q[$];
   logic [4:0] m_fl = 5'b0;
   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .i_clk              (clk),
      .i_rst              (s.rst),
      .i_alu_funct        (s.funct),
      .i_alu_src_mux      (s.alu_src),
      .i_reg_dst_mux      (s.reg_dst),
      .i_is_load          (s.is_load),
      .i_fl_write_enable  (s.fwe),
      .i_mem_write_enable (s.mwe),
      .i_sel_beq_bne      (s.beq_bne),
      .i_sel_jt_jf        (s.jt_jf),
      .i_is_branch        (s.is_branch),
      .i_sel_jflag_branch (s.jflag),
      .i_wb_res_mux       (s.wb_mux),
      .i_reg_write_enable (s.rwe),
      .i_rd               (s.rd),
      .i_rs               (s.rs),
      .i_rt               (s.rt),
      .i_imm              (s.imm),
      .i_next_pc          (s.next_pc),
      .i_data_rs          (s.data_rs),
      .i_data_rt          (s.data_rt),
      .i_fw_sel_a         (s.fw_a),
      .i_fw_sel_b         (s.fw_b),
      .i_mem_fw_data      (s.mem_fw),
      .i_wb_fw_data       (s.wb_fw),
      .o_branch_taken     (branch_taken),
      .o_branch_addr      (branch_addr),
      .o_alu_res          (alu_res),
      .o_data_rt          (data_rt),
      .o_imm              (imm),
      .o_next_pc          (next_pc),
      .o_wr_reg           (wr_reg),
      .o_is_load          (is_load),
      .o_mem_write_enable (mwe),
      .o_reg_write_enable (rwe),
      .o_wb_res_mux       (wb_mux),
      .o_flags            (flags)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
   endtask

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] d,
                                       input logic [31:0] m, input logic [31:0] w);
      if (sel == 2'd1) return m;
      if (sel == 2'd2) return w;
      return d;
   endfunction

   // Reference ALU from arithmetic definitions of each operation
   task automatic ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [4:0] fl);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint wide;
      logic c = 1'b0, v = 1'b0, known = 1'b1;
      int sh = int'(b[4:0]);
      r = 32'h0;
      case (f)
         FN_ADD: begin
            r = a + b;
            c = (longint'(a) + longint'(b)) > 64'sd4294967295;
            wide = sa + sb;
            v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         FN_SUB: begin
            r = a - b;
            c = (a < b);
            wide = sa - sb;
            v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         FN_AND:  r = a & b;
         FN_OR:   r = a | b;
         FN_NOT:  r = ~a;
         FN_XOR:  r = a ^ b;
         FN_NOR:  r = ~(a | b);
         FN_XNOR: r = ~(a ^ b);
         FN_NAND: r = ~(a & b);
         FN_LSL:  r = a << sh;
         FN_LSR:  r = a >> sh;
         FN_ASR:  r = 32'(sa >>> sh);
         FN_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
         default: known = 1'b0;
      endcase
      fl = known ? {1'b1, v, c, (r == 32'h0), r[31]} : 5'b0;
   endtask

   // Drive one instruction at the falling edge and queue its expected responses
   task automatic issue(input stim_t st);
      logic [31:0] a, fb, b, r;
      logic [4:0]  fl, wr;
      logic        cond, tk;
      exp_t        e;
      br_t         bt;
      @(negedge clk);
      s = st;
      a  = fwd(st.fw_a, st.data_rs, st.mem_fw, st.wb_fw);
      fb = fwd(st.fw_b, st.data_rt, st.mem_fw, st.wb_fw);
      b  = st.alu_src ? st.imm : fb;
      ref_alu(st.funct, a, b, r, fl);
      cond = (int'(st.rs) < 5) ? m_fl[int'(st.rs)] : 1'b0;
      tk = 1'b0;
      if (st.is_branch) tk = st.jflag ? (cond ^ st.jt_jf) : ((a == b) ^ st.beq_bne);
      bt.taken = tk;
      bt.addr  = st.next_pc + st.imm;
      br_q.push_back(bt);
      if (st.rst) begin
         m_fl = 5'b0;
         e = '0;
      end else begin
         case (st.reg_dst)
            2'd0: wr = st.rd;
            2'd1: wr = st.rt;
            2'd2: wr = 5'd31;
            default: wr = 5'd0;
         endcase
         if (st.fwe) m_fl = fl;
         e.alu_res = r;
         e.data_rt = fb;
         e.imm     = st.imm;
         e.next_pc = st.next_pc;
         e.wr_reg  = wr;
         e.ctl     = {st.is_load, st.mwe, st.rwe, st.wb_mux};
         e.flags   = m_fl;
      end
      exp_q.push_back(e);
   endtask

   // EX/MEM monitor: one queued expectation per clock edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("alu_res", 64'(alu_res), 64'(e.alu_res));
            check("data_rt", 64'(data_rt), 64'(e.data_rt));
            check("imm", 64'(imm), 64'(e.imm));
            check("next_pc", 64'(next_pc), 64'(e.next_pc));
            check("wr_reg", 64'(wr_reg), 64'(e.wr_reg));
            check("ctl", 64'({is_load, mwe, rwe, wb_mux}), 64'(e.ctl));
            check("flags", 64'(flags), 64'(e.flags));
         end
      end
   end

   // Branch monitor: combinational outputs sampled mid low phase
   initial begin
      br_t bt;
      forever begin
         @(negedge clk);
         #2;
         if (br_q.size() > 0) begin
            bt = br_q.pop_front();
            check("branch_taken", 64'(branch_taken), 64'(bt.taken));
            check("branch_addr", 64'(branch_addr), 64'(bt.addr));
         end
      end
   end

   function automatic stim_t nop();
      stim_t t = '0;
      t.funct = FN_ADD;
      return t;
   endfunction

   function automatic stim_t rand_stim();
      logic [5:0] fns [13] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOT, FN_XOR, FN_NOR,
                               FN_XNOR, FN_NAND, FN_LSL, FN_LSR, FN_ASR, FN_SLT};
      stim_t t;
      t = stim_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom});
      t.rst   = ($urandom_range(0, 31) == 0);
      t.funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 12)];
      if ($urandom_range(0, 3) == 0) t.data_rt = t.data_rs;
      if ($urandom_range(0, 3) == 0) t.mem_fw = t.data_rs;
      if ($urandom_range(0, 3) == 0) t.imm = 32'($urandom_range(0, 40));
      if ($urandom_range(0, 2) == 0) t.rs = 5'($urandom_range(0, 6));
      return t;
   endfunction

   initial begin
      stim_t t;
      s = nop();
      s.rst = 1'b1;
      t = nop(); t.rst = 1'b1;
      issue(t);
      issue(t);

      // Signed overflow on ADD, flags written
      t = nop(); t.funct = FN_ADD; t.data_rs = 32'h7FFF_FFFF; t.data_rt = 32'h1; t.fwe = 1'b1;
      issue(t);
      @(posedge clk); #1;
      check("ovf_add_res", 64'(alu_res), 64'h8000_0000);
      check("ovf_add_flags", 64'(flags), 64'b11001);

      // SUB 5-5 sets zero, then JT on zero flag
      t = nop(); t.funct = FN_SUB; t.data_rs = 32'd5; t.data_rt = 32'd5; t.fwe = 1'b1;
      issue(t);
      t = nop(); t.is_branch = 1'b1; t.jflag = 1'b1; t.rs = 5'd1;
      t.next_pc = 32'h0000_1000; t.imm = 32'h0000_0040;
      issue(t);
      #1;
      check("jt_zero_taken", 64'(branch_taken), 64'd1);
      check("jt_zero_addr", 64'(branch_addr), 64'h1040);

      // BNE with forwarded equal operands is not taken
      t = nop(); t.is_branch = 1'b1; t.beq_bne = 1'b1; t.data_rs = 32'd3; t.data_rt = 32'd4;
      t.fw_b = 2'd1; t.mem_fw = 32'd3;
      issue(t);
      #1;
      check("bne_fw_taken", 64'(branch_taken), 64'd0);

      // Arithmetic vs logical right shift
      t = nop(); t.funct = FN_ASR; t.data_rs = 32'h8000_0000; t.alu_src = 1'b1; t.imm = 32'd4;
      issue(t);
      @(posedge clk); #1;
      check("asr_res", 64'(alu_res), 64'hF800_0000);
      t.funct = FN_LSR;
      issue(t);
      @(posedge clk); #1;
      check("lsr_res", 64'(alu_res), 64'h0800_0000);

      // JAL-style write then reset next cycle with a flag write pending
      t = nop(); t.reg_dst = 2'd2; t.rwe = 1'b1; t.next_pc = 32'h44; t.fwe = 1'b1;
      issue(t);
      @(posedge clk); #1;
      check("jal_wr_reg", 64'(wr_reg), 64'd31);
      t = rand_stim(); t.rst = 1'b1; t.fwe = 1'b1;
      issue(t);
      @(posedge clk); #1;
      check("rst_wr_reg", 64'(wr_reg), 64'd0);
      check("rst_flags", 64'(flags), 64'd0);
      check("rst_rwe", 64'(rwe), 64'd0);

      // Wrap-around branch target
      t = nop(); t.next_pc = 32'hFFFF_FFF0; t.imm = 32'h0000_0020;
      issue(t);
      #1;
      check("addr_wrap", 64'(branch_addr), 64'h10);

      for (int i = 0; i < 400; i++) issue(rand_stim());

      repeat (3) @(posedge clk);
      #2;
      check("queues_drained", 64'(exp_q.size() + br_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
